// File: rtl/instr_fetch_queue_if.sv
// Bundles the two handshakes around the fetch stage: the req/ack port to
// instruction memory and the valid/ready port (plus redirect) to the core.
// The master modport is the fetch queue's view; slave is the view of the
// memory/core that surround it.
interface instr_fetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    input  redirect, redirect_pc, mem_ack, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect, redirect_pc, mem_ack, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues one word fetch at a time to a multi-cycle
// instruction memory, buffers {pc, word} pairs in a DEPTH-entry FIFO and
// hands them to the core over valid/ready. A redirect flushes the FIFO and
// restarts fetching; a fetch already in flight is drained and its data
// dropped. Optional macro FETCH_PERF_EN adds the perf_bubbles counter that
// counts cycles where the core was ready but no instruction was available.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clock,
  input  logic                reset,
`ifdef FETCH_PERF_EN
  output logic [31:0]         perf_bubbles,
`endif
  instr_fetch_queue_if.master bus
);
  localparam int unsigned      PTR_W            = $clog2(DEPTH);
  localparam int unsigned      CNT_W            = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT         = CNT_W'(DEPTH);
  localparam logic [31:0]      PC_ALIGN_MASK    = 32'hFFFF_FFFC;
  localparam logic [31:0]      RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;

  // RUN: idle, WAIT: fetch in flight and kept, DRAIN: fetch in flight and dropped
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [31:0]      fetch_pc_r;
  logic [31:0]      req_addr_r;
  logic [31:0]      pc_mem_r   [DEPTH];
  logic [31:0]      word_mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic             valid_s;
  logic             issue_s;
  logic             push_s;
  logic             pop_s;
  logic             mem_req_s;
  logic [31:0]      mem_addr_s;
  logic [31:0]      redirect_pc_s;

  assign redirect_pc_s = bus.redirect_pc & PC_ALIGN_MASK;
  assign valid_s       = (count_r != {CNT_W{1'b0}});
  // A new fetch starts only from RUN with room left; redirect takes priority.
  assign issue_s       = (state_r == ST_RUN) && !reset && !bus.redirect && (count_r < FULL_CNT);
  assign push_s        = (state_r == ST_WAIT) && bus.mem_ack && !bus.redirect;
  assign pop_s         = valid_s && bus.instr_ready && !bus.redirect;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: a request, once raised, is held until its ack
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (issue_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (bus.mem_ack) begin
          state_nxt_s = ST_RUN;
        end else if (bus.redirect) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (bus.mem_ack) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // FSM outputs: address comes from fetch_pc in RUN, from the latched request otherwise
  always_comb begin
    mem_req_s  = 1'b0;
    mem_addr_s = fetch_pc_r;
    case (state_r)
      ST_RUN: begin
        mem_req_s  = issue_s;
        mem_addr_s = fetch_pc_r;
      end
      ST_WAIT, ST_DRAIN: begin
        mem_req_s  = 1'b1;
        mem_addr_s = req_addr_r;
      end
      default: begin
        mem_req_s  = 1'b0;
        mem_addr_s = fetch_pc_r;
      end
    endcase
  end

  // Fetch PC, in-flight address, FIFO pointers and occupancy; redirect flushes
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC_ALIGNED;
      req_addr_r <= RESET_PC_ALIGNED;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      count_r    <= '0;
    end else begin
      if (issue_s) begin
        req_addr_r <= fetch_pc_r;
      end
      if (bus.redirect) begin
        fetch_pc_r <= redirect_pc_s;
        rd_ptr_r   <= '0;
        wr_ptr_r   <= '0;
        count_r    <= '0;
      end else begin
        if (push_s) begin
          wr_ptr_r   <= wr_ptr_r + PTR_W'(1);
          fetch_pc_r <= fetch_pc_r + 32'd4;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CNT_W'(1);
          2'b01:   count_r <= count_r - CNT_W'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // FIFO storage write; contents are only observable while counted valid
  always_ff @(posedge clock) begin
    if (push_s && !reset) begin
      pc_mem_r[wr_ptr_r]   <= req_addr_r;
      word_mem_r[wr_ptr_r] <= bus.mem_rdata;
    end
  end

  assign bus.mem_req     = mem_req_s;
  assign bus.mem_addr    = mem_addr_s;
  assign bus.instr_valid = valid_s;
  assign bus.instr       = valid_s ? word_mem_r[rd_ptr_r] : 32'h0000_0000;
  assign bus.instr_pc    = valid_s ? pc_mem_r[rd_ptr_r]   : 32'h0000_0000;

`ifdef FETCH_PERF_EN
  // Count cycles where the core wanted an instruction and none was buffered
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_bubbles <= 32'h0000_0000;
    end else if (bus.instr_ready && !valid_s) begin
      perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule
